// File: rtl/present80_dec_core_if.sv
// Request/response bundle for the PRESENT-80 decrypt core.
// The reuse_key signal exists only when PRESENT_KEYCACHE_EN is defined.
interface present80_dec_core_if;
  logic        start;
  logic [79:0] key;
  logic [63:0] idat;
`ifdef PRESENT_KEYCACHE_EN
  logic        reuse_key;
`endif
  logic        busy;
  logic        done;
  logic [63:0] odat;

`ifdef PRESENT_KEYCACHE_EN
  modport master (output start, key, idat, reuse_key, input busy, done, odat);
  modport slave  (input start, key, idat, reuse_key, output busy, done, odat);
`else
  modport master (output start, key, idat, input busy, done, odat);
  modport slave  (input start, key, idat, output busy, done, odat);
`endif
endinterface

// File: rtl/present80_dec_core.sv
// Iterative PRESENT-80 decryption: forward key expansion to K32, then 31 inverse rounds.
// Optional K32 cache (skips key expansion on reuse) enabled by PRESENT_KEYCACHE_EN.
module present80_dec_core #(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  present80_dec_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC, FINAL} fsm_t;

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);
  localparam logic [3:0] SBOX     [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] INV_SBOX [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                          4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  // Forward pLayer moves bit i to 16*i mod 63, so the inverse gathers from there.
  function automatic logic [63:0] inv_p(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 63; i++) o[i] = s[(i * 16) % 63];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = INV_SBOX[s[4*n +: 4]];
    return o;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = SBOX[t[79:76]];
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  // Exact inverse of key_fwd: undo the counter XOR, the S-box, then the rotation.
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rc;
    t[79:76]   = INV_SBOX[t[79:76]];
    return {t[60:0], t[79:61]};
  endfunction

  fsm_t        fsm, fsm_nxt;
  logic [63:0] state;
  logic [79:0] kreg;
  logic [4:0]  rc;
  logic        busy_q, done_q;
  logic [63:0] odat_q;
  logic        use_cache;

`ifdef PRESENT_KEYCACHE_EN
  logic [79:0] cache_key;
  logic        cache_vld;

  assign use_cache = bus.reuse_key && cache_vld;

  // NOTE: only the valid bit needs reset; the key word is never read while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cache_vld <= 1'b0;
    else if (fsm == KEYEXP && rc == LAST_RC) cache_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fsm == KEYEXP && rc == LAST_RC) cache_key <= key_fwd(kreg, rc);
  end
`else
  assign use_cache = 1'b0;
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:   if (bus.start) fsm_nxt = use_cache ? DEC : KEYEXP;
      KEYEXP: if (rc == LAST_RC) fsm_nxt = DEC;
      DEC:    if (rc == 5'd1) fsm_nxt = FINAL;
      FINAL:  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= '0;
      kreg   <= '0;
      rc     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      odat_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm)
        IDLE: if (bus.start) begin
          state  <= bus.idat;
          busy_q <= 1'b1;
`ifdef PRESENT_KEYCACHE_EN
          if (use_cache) begin
            kreg <= cache_key;
            rc   <= LAST_RC;
          end else begin
            kreg <= bus.key;
            rc   <= 5'd1;
          end
`else
          kreg <= bus.key;
          rc   <= 5'd1;
`endif
        end
        KEYEXP: begin
          kreg <= key_fwd(kreg, rc);
          if (rc != LAST_RC) rc <= rc + 5'd1;
        end
        DEC: begin
          state <= inv_s_layer(inv_p(state ^ kreg[79:16]));
          kreg  <= key_inv(kreg, rc);
          rc    <= rc - 5'd1;
        end
        FINAL: begin
          odat_q <= state ^ kreg[79:16];
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.odat = odat_q;

endmodule

// File: tb/tb_present80_dec_core.sv
// Directed scoreboard bench for present80_dec_core using known PRESENT-80 vectors.
// Extra cache-reuse steps run when PRESENT_KEYCACHE_EN is defined.
module tb_present80_dec_core;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  present80_dec_core_if bus();

  present80_dec_core #(.ROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start spans exactly one rising edge (E0).
  task automatic do_start(input logic [79:0] k, input logic [63:0] d, input logic reuse,
                          input logic [63:0] exp, input string tag);
    bus.start = 1'b1;
    bus.key   = k;
    bus.idat  = d;
`ifdef PRESENT_KEYCACHE_EN
    bus.reuse_key = reuse;
`else
    if (reuse) $display("note: reuse_key ignored in this build (%s)", tag);
`endif
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy, 1'b1);
    check({tag, "_done_low_after_start"}, bus.done, 1'b0);
  endtask

  // Counts edges after E0 until done; optionally pulses a stray start at edge count pulse_at.
  task automatic wait_done(input int exp_lat, input int pulse_at, input string tag);
    int cnt = 0;
    int busy_cnt = 1;
    bit seen = 1'b0;
    logic [63:0] exp;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt == pulse_at) begin
        bus.start = 1'b1;
        bus.key   = '1;
        bus.idat  = 64'h5579C1387B228445;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      check({tag, "_odat"}, bus.odat, exp);
      check({tag, "_latency"}, cnt, exp_lat);
      check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
      check({tag, "_busy_low_at_done"}, bus.busy, 1'b0);
    end
  endtask

  task automatic no_done_for(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check({tag, "_no_extra_done"}, seen, 0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.key   = '0;
    bus.idat  = '0;
`ifdef PRESENT_KEYCACHE_EN
    bus.reuse_key = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_odat", bus.odat, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero key, ciphertext of all-zero plaintext.
    do_start(80'h0, 64'h5579C1387B228445, 1'b0, 64'h0, "k0_z");
    wait_done(63, 0, "k0_z");
    @(negedge clk);
    check("k0_z_done_one_cycle", bus.done, 1'b0);
    check("k0_z_odat_held", bus.odat, 64'h0);
    repeat (3) @(negedge clk);

    // All-ones key, then a back-to-back block started in the done cycle.
    do_start('1, 64'hE72C46C0F5945049, 1'b0, 64'h0, "kf_z");
    wait_done(63, 0, "kf_z");
    do_start('1, 64'h3333DCD3213210D2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "kf_f_b2b");
    wait_done(63, 0, "kf_f_b2b");
    repeat (3) @(negedge clk);

    // A stray start while busy must be ignored.
    do_start(80'h0, 64'hA112FFC72F68417B, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "k0_f_stray");
    wait_done(63, 20, "k0_f_stray");
    no_done_for(70, "k0_f_stray");

    // Reset mid-block aborts with no completion.
    do_start('1, 64'hE72C46C0F5945049, 1'b0, 64'h0, "abort");
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_odat", bus.odat, 64'h0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for(70, "abort");
    do_start('1, 64'h3333DCD3213210D2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "after_abort");
    wait_done(63, 0, "after_abort");

`ifdef PRESENT_KEYCACHE_EN
    // Reuse right after reset finds the cache invalid, then a true reuse skips expansion.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(80'h0, 64'h5579C1387B228445, 1'b1, 64'h0, "kc_cold");
    wait_done(63, 0, "kc_cold");
    do_start('1, 64'hA112FFC72F68417B, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "kc_reuse");
    wait_done(32, 0, "kc_reuse");
`endif

    check("sb_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
